// File: rtl/id_ex_stage.sv
// ID/EX boundary register with write-back bypass, load-use bubble insertion and a saturating stall counter.
// One cycle id_* to ex_*; ex_hold freezes EX and id_stall (lu | ex_hold) holds the upstream stages.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_PR1,
  input  logic [REG_W-1:0]  id_PR2,
  input  logic [REG_W-1:0]  id_WR,
  input  logic [DATA_W-1:0] id_RD1,
  input  logic [DATA_W-1:0] id_RD2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_write,
  input  logic [REG_W-1:0]  wb_WR,
  input  logic [DATA_W-1:0] wb_WD,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_PR1,
  output logic [REG_W-1:0]  ex_PR2,
  output logic [REG_W-1:0]  ex_WR,
  output logic [DATA_W-1:0] ex_RD1,
  output logic [DATA_W-1:0] ex_RD2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] byp1;
  logic [DATA_W-1:0] byp2;
  logic              lu;
  logic              kill;

  // reg_file write lands on the same edge we capture, so forward it here; r0 is hardwired zero
  always_comb begin
    byp1 = id_RD1;
    byp2 = id_RD2;
    if (wb_write && (wb_WR == id_PR1) && (id_PR1 != '0)) byp1 = wb_WD;
    if (wb_write && (wb_WR == id_PR2) && (id_PR2 != '0)) byp2 = wb_WD;
  end

  assign lu = ex_valid && ex_ctrl[1] && (ex_WR != '0) && id_valid &&
              ((ex_WR == id_PR1) || (ex_WR == id_PR2));
  assign id_stall = lu | ex_hold;

  // a load-use bubble is encoded exactly like a flush, but a hold suppresses it
  assign kill = reset | flush | (lu & ~ex_hold);

  always_ff @(posedge clk) begin
    if (kill) begin
      ex_valid <= 1'b0;
      ex_PR1   <= '0;
      ex_PR2   <= '0;
      ex_WR    <= '0;
      ex_RD1   <= '0;
      ex_RD2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
    end else if (!ex_hold) begin
      ex_valid <= id_valid;
      ex_PR1   <= id_PR1;
      ex_PR2   <= id_PR2;
      ex_WR    <= id_WR;
      ex_RD1   <= byp1;
      ex_RD2   <= byp2;
      ex_imm   <= id_imm;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!flush && !ex_hold && lu && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded directed bench for id_ex_stage; a CNT_W=2 twin shares the stimulus to exercise saturation.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_PR1, id_PR2, id_WR;
  logic [31:0] id_RD1, id_RD2, id_imm;
  logic [8:0]  id_ctrl;
  logic        wb_write;
  logic [4:0]  wb_WR;
  logic [31:0] wb_WD;
  logic        flush, ex_hold;

  logic        id_stall, ex_valid;
  logic [4:0]  ex_PR1, ex_PR2, ex_WR;
  logic [31:0] ex_RD1, ex_RD2, ex_imm;
  logic [8:0]  ex_ctrl;
  logic [15:0] stall_cnt;

  logic        s_id_stall, s_ex_valid;
  logic [4:0]  s_ex_PR1, s_ex_PR2, s_ex_WR;
  logic [31:0] s_ex_RD1, s_ex_RD2, s_ex_imm;
  logic [8:0]  s_ex_ctrl;
  logic [1:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        st;
    logic        v;
    logic [4:0]  pr1, pr2, wr;
    logic [31:0] rd1, rd2, imm;
    logic [8:0]  ctrl;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t q[$];

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_PR1(id_PR1), .id_PR2(id_PR2), .id_WR(id_WR),
    .id_RD1(id_RD1), .id_RD2(id_RD2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_write(wb_write), .wb_WR(wb_WR), .wb_WD(wb_WD),
    .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_PR1(ex_PR1), .ex_PR2(ex_PR2), .ex_WR(ex_WR),
    .ex_RD1(ex_RD1), .ex_RD2(ex_RD2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_PR1(id_PR1), .id_PR2(id_PR2), .id_WR(id_WR),
    .id_RD1(id_RD1), .id_RD2(id_RD2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_write(wb_write), .wb_WR(wb_WR), .wb_WD(wb_WD),
    .flush(flush), .ex_hold(ex_hold), .id_stall(s_id_stall),
    .ex_valid(s_ex_valid), .ex_PR1(s_ex_PR1), .ex_PR2(s_ex_PR2), .ex_WR(s_ex_WR),
    .ex_RD1(s_ex_RD1), .ex_RD2(s_ex_RD2), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl),
    .stall_cnt(s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic idslot(input logic v, input logic [4:0] p1, input logic [4:0] p2,
                        input logic [4:0] w, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic [8:0] c);
    id_valid = v; id_PR1 = p1; id_PR2 = p2; id_WR = w;
    id_RD1 = r1; id_RD2 = r2; id_imm = im; id_ctrl = c;
  endtask

  task automatic expect_ex(input logic st, input logic v, input logic [4:0] p1,
                           input logic [4:0] p2, input logic [4:0] w, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] im, input logic [8:0] c,
                           input logic [15:0] cn, input logic [1:0] cn2);
    exp_t e;
    e.st = st; e.v = v; e.pr1 = p1; e.pr2 = p2; e.wr = w;
    e.rd1 = r1; e.rd2 = r2; e.imm = im; e.ctrl = c; e.cnt = cn; e.cnt2 = cn2;
    q.push_back(e);
  endtask

  // monitor: id_stall is sampled just before the edge, ex_* just after it
  initial begin
    exp_t e;
    logic st_s;
    forever begin
      @(negedge clk);
      #4;
      st_s = id_stall;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("id_stall",  32'(st_s),        32'(e.st));
        cmp("ex_valid",  32'(ex_valid),    32'(e.v));
        cmp("ex_PR1",    32'(ex_PR1),      32'(e.pr1));
        cmp("ex_PR2",    32'(ex_PR2),      32'(e.pr2));
        cmp("ex_WR",     32'(ex_WR),       32'(e.wr));
        cmp("ex_RD1",    ex_RD1,           e.rd1);
        cmp("ex_RD2",    ex_RD2,           e.rd2);
        cmp("ex_imm",    ex_imm,           e.imm);
        cmp("ex_ctrl",   32'(ex_ctrl),     32'(e.ctrl));
        cmp("stall_cnt", 32'(stall_cnt),   32'(e.cnt));
        cmp("sat_cnt",   32'(s_stall_cnt), 32'(e.cnt2));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    wb_write = 1'b0; wb_WR = '0; wb_WD = '0;
    idslot(0, 0, 0, 0, 0, 0, 0, 0);

    // reset then idle
    @(negedge clk); reset = 1'b1;
    expect_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    expect_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // pass-through
    @(negedge clk); idslot(1, 6, 8, 3, 6, 8, 32'h10, 9'h021);
    expect_ex(0, 1, 6, 8, 3, 6, 8, 32'h10, 9'h021, 0, 0);

    // write-back bypass on RD1
    @(negedge clk); wb_write = 1; wb_WR = 4; wb_WD = 31;
    idslot(1, 4, 9, 7, 0, 32'h55, 32'hFFFF_FFFC, 9'h011);
    expect_ex(0, 1, 4, 9, 7, 31, 32'h55, 32'hFFFF_FFFC, 9'h011, 0, 0);

    // r0 never bypassed
    @(negedge clk); wb_WR = 0;
    idslot(1, 0, 4, 2, 32'h77, 32'h12, 0, 9'h001);
    expect_ex(0, 1, 0, 4, 2, 32'h77, 32'h12, 0, 9'h001, 0, 0);

    // index match but write disabled, then enabled on RD2
    @(negedge clk); wb_write = 0; wb_WR = 8; wb_WD = 99;
    idslot(1, 8, 8, 1, 32'hA, 32'hB, 0, 9'h001);
    expect_ex(0, 1, 8, 8, 1, 32'hA, 32'hB, 0, 9'h001, 0, 0);
    @(negedge clk); wb_write = 1;
    idslot(1, 3, 8, 1, 32'hA, 32'hB, 0, 9'h001);
    expect_ex(0, 1, 3, 8, 1, 32'hA, 99, 0, 9'h001, 0, 0);

    // load-use: load r5, then consumer of r5 on PR2
    @(negedge clk); wb_write = 0;
    idslot(1, 1, 2, 5, 32'h100, 32'h200, 32'h4, 9'h00B);
    expect_ex(0, 1, 1, 2, 5, 32'h100, 32'h200, 32'h4, 9'h00B, 0, 0);
    @(negedge clk); idslot(1, 7, 5, 6, 32'h300, 32'h400, 32'h8, 9'h001);
    expect_ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    expect_ex(0, 1, 7, 5, 6, 32'h300, 32'h400, 32'h8, 9'h001, 1, 1);

    // flush beats hold and load-use; counter unchanged
    @(negedge clk); idslot(1, 0, 0, 5, 1, 2, 3, 9'h00B);
    expect_ex(0, 1, 0, 0, 5, 1, 2, 3, 9'h00B, 1, 1);
    @(negedge clk); flush = 1; ex_hold = 1;
    idslot(1, 5, 0, 4, 32'h9, 32'h9, 32'h9, 9'h001);
    expect_ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // hold for 3 cycles with a pending load-use: frozen, no count
    @(negedge clk); flush = 0; ex_hold = 0;
    idslot(1, 2, 3, 9, 32'hAA, 32'hBB, 32'hCC, 9'h0E3);
    expect_ex(0, 1, 2, 3, 9, 32'hAA, 32'hBB, 32'hCC, 9'h0E3, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ex_hold = 1;
      idslot(1, 9, 4, 2, 32'h11, 32'h22, 32'h33, 9'h001);
      expect_ex(1, 1, 2, 3, 9, 32'hAA, 32'hBB, 32'hCC, 9'h0E3, 1, 1);
    end
    @(negedge clk); ex_hold = 0;
    expect_ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
    @(negedge clk);
    expect_ex(0, 1, 9, 4, 2, 32'h11, 32'h22, 32'h33, 9'h001, 2, 2);

    // repeated load-use pairs: 2-bit twin saturates at 3
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idslot(1, 0, 0, 5, 0, 0, 0, 9'h00B);
      expect_ex(0, 1, 0, 0, 5, 0, 0, 0, 9'h00B, 16'(2 + k), (k == 0) ? 2'd2 : 2'd3);
      @(negedge clk); idslot(1, 5, 0, 1, 0, 0, 0, 9'h001);
      expect_ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'(3 + k), 2'd3);
      @(negedge clk);
      expect_ex(0, 1, 5, 0, 1, 0, 0, 0, 9'h001, 16'(3 + k), 2'd3);
    end

    // invalid slot never triggers load-use and loads with ctrl=0
    @(negedge clk); idslot(1, 0, 0, 5, 0, 0, 0, 9'h00B);
    expect_ex(0, 1, 0, 0, 5, 0, 0, 0, 9'h00B, 5, 3);
    @(negedge clk); idslot(0, 5, 5, 0, 1, 2, 3, 9'h001);
    expect_ex(0, 0, 5, 5, 0, 1, 2, 3, 9'h000, 5, 3);

    // reset during a load-use stall clears everything
    @(negedge clk); idslot(1, 0, 0, 5, 0, 0, 0, 9'h00B);
    expect_ex(0, 1, 0, 0, 5, 0, 0, 0, 9'h00B, 5, 3);
    @(negedge clk); reset = 1; idslot(1, 5, 0, 1, 0, 0, 0, 9'h001);
    expect_ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 0; idslot(0, 0, 0, 0, 0, 0, 0, 0);
    expect_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    cmp("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
